// File: rtl/draw_write_arbiter_if.sv
// Pixel-request and Avalon-MM write bundle for draw_write_arbiter.
// The slave modport is the arbiter's view: it is the sink of both draw
// sources and drives the SDRAM write port. The master modport is the
// environment: the two draw sources plus the Avalon slave.
interface draw_write_arbiter_if #(
  parameter int X_W     = 10,
  parameter int Y_W     = 10,
  parameter int COLOR_W = 16,
  parameter int ADDR_W  = 32
);
  logic               a_valid;
  logic               a_ready;
  logic [X_W-1:0]     a_x;
  logic [Y_W-1:0]     a_y;
  logic [COLOR_W-1:0] a_color;
  logic               b_valid;
  logic               b_ready;
  logic [X_W-1:0]     b_x;
  logic [Y_W-1:0]     b_y;
  logic [COLOR_W-1:0] b_color;
  logic [ADDR_W-1:0]  avm_address;
  logic               avm_write;
  logic [COLOR_W-1:0] avm_writedata;
  logic               avm_waitrequest;
  logic [15:0]        drop_count;
  logic               busy;

  modport slave (
    input  a_valid, a_x, a_y, a_color,
    input  b_valid, b_x, b_y, b_color,
    input  avm_waitrequest,
    output a_ready, b_ready,
    output avm_address, avm_write, avm_writedata,
    output drop_count, busy
  );

  modport master (
    output a_valid, a_x, a_y, a_color,
    output b_valid, b_x, b_y, b_color,
    output avm_waitrequest,
    input  a_ready, b_ready,
    input  avm_address, avm_write, avm_writedata,
    input  drop_count, busy
  );
endinterface

// File: rtl/draw_write_arbiter.sv
// Round-robin arbiter sharing the SDRAM framebuffer write path between the
// touch-panel (A) and wifi-UART (B) draw sources. Each accepted in-range
// pixel becomes one Avalon-MM write; out-of-range pixels are dropped and
// counted with a saturating counter.

// Per-source range check and pixel-to-byte-address conversion.
module draw_write_arbiter_lane #(
  parameter int unsigned H_RES     = 640,
  parameter int unsigned V_RES     = 480,
  parameter int          X_W       = 10,
  parameter int          Y_W       = 10,
  parameter int          ADDR_W    = 32,
  parameter int unsigned BYTES     = 2,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic [X_W-1:0]    x,
  input  logic [Y_W-1:0]    y,
  output logic              in_range,
  output logic [ADDR_W-1:0] addr
);
  assign in_range = (32'(x) < H_RES) && (32'(y) < V_RES);
  // Only registered when in_range is set, so the product never wraps
  // for any value that reaches the bus.
  assign addr = BASE_ADDR
              + (ADDR_W'(y) * ADDR_W'(H_RES) + ADDR_W'(x)) * ADDR_W'(BYTES);
endmodule

module draw_write_arbiter #(
  parameter int unsigned H_RES     = 640,
  parameter int unsigned V_RES     = 480,
  parameter int          X_W       = 10,
  parameter int          Y_W       = 10,
  parameter int          COLOR_W   = 16,   // 8, 16 or 32
  parameter int          ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic clk_clk,
  input  logic reset_reset,
  draw_write_arbiter_if.slave bus
);
  localparam int          NUM_SRC = 2;     // index 0 = A, 1 = B
  localparam int unsigned BYTES   = COLOR_W / 8;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                            state;
  logic                              last_grant;  // 0 = A, 1 = B
  logic [ADDR_W-1:0]                 addr_q;
  logic [COLOR_W-1:0]                data_q;
  logic                              write_q;
  logic [15:0]                       drop_q;

  logic [NUM_SRC-1:0]                src_valid;
  logic [NUM_SRC-1:0][X_W-1:0]       src_x;
  logic [NUM_SRC-1:0][Y_W-1:0]       src_y;
  logic [NUM_SRC-1:0][COLOR_W-1:0]   src_color;
  logic [NUM_SRC-1:0]                src_in_range;
  logic [NUM_SRC-1:0][ADDR_W-1:0]    src_addr;
  logic [NUM_SRC-1:0]                grant;
  logic                              sel;

  assign src_valid = {bus.b_valid, bus.a_valid};
  assign src_x     = {bus.b_x, bus.a_x};
  assign src_y     = {bus.b_y, bus.a_y};
  assign src_color = {bus.b_color, bus.a_color};

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_lane
    draw_write_arbiter_lane #(
      .H_RES(H_RES), .V_RES(V_RES), .X_W(X_W), .Y_W(Y_W),
      .ADDR_W(ADDR_W), .BYTES(BYTES), .BASE_ADDR(BASE_ADDR)
    ) u_lane (
      .x        (src_x[g]),
      .y        (src_y[g]),
      .in_range (src_in_range[g]),
      .addr     (src_addr[g])
    );
  end

  // Grant only in IDLE; a tie goes to the source that did not win last.
  // Deliberately independent of avm_waitrequest.
  always_comb begin
    grant = '0;
    if (state == IDLE) begin
      if (&src_valid) grant = last_grant ? 2'b01 : 2'b10;
      else            grant = src_valid;
    end
  end

  assign sel         = grant[1];
  assign bus.a_ready = grant[0];
  assign bus.b_ready = grant[1];

  // Accept/drop in IDLE, hold the write in ISSUE until the slave takes it.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      addr_q     <= '0;
      data_q     <= '0;
      write_q    <= 1'b0;
      drop_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            last_grant <= sel;
            if (src_in_range[sel]) begin
              addr_q  <= src_addr[sel];
              data_q  <= src_color[sel];
              write_q <= 1'b1;
              state   <= ISSUE;
            end else if (drop_q != 16'hFFFF) begin
              drop_q <= drop_q + 16'd1;
            end
          end
        end
        ISSUE: begin
          if (!bus.avm_waitrequest) begin
            write_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.avm_address   = addr_q;
  assign bus.avm_writedata = data_q;
  assign bus.avm_write     = write_q;
  assign bus.drop_count    = drop_q;
  assign bus.busy          = (state == ISSUE);
endmodule

// File: tb/tb_draw_write_arbiter.sv
// Directed and randomized checks of draw_write_arbiter against a
// cycle-level reference built from the pixel/handshake rules.
module tb_draw_write_arbiter;
  localparam int X_W = 10, Y_W = 10, COLOR_W = 16, ADDR_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  draw_write_arbiter_if #(.X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W), .ADDR_W(ADDR_W)) bus ();

  draw_write_arbiter #(
    .H_RES(640), .V_RES(480), .X_W(X_W), .Y_W(Y_W),
    .COLOR_W(COLOR_W), .ADDR_W(ADDR_W), .BASE_ADDR(32'h0)
  ) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .bus         (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference state: a write pending or not, who won last, how many drops.
  bit          m_busy;
  bit          m_last;     // 0 = A, 1 = B
  int          m_drops;
  logic [31:0] m_addr;
  logic [15:0] m_data;
  bit          g_a, g_b;   // reference grants for the current cycle
  bit          log_en = 0;
  int          grant_log[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pix_addr(input int x, input int y);
    return 32'((y * 640 + x) * 2);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_last = 1; m_drops = 0; m_addr = '0; m_data = '0;
  endtask

  // Inputs are applied at posedge+1; check mid-cycle, advance the model
  // across the edge, and return at the next posedge+1.
  task automatic step();
    int sx, sy;
    logic [15:0] sc;
    #3;
    g_a = !m_busy && bus.a_valid && (!bus.b_valid || m_last);
    g_b = !m_busy && bus.b_valid && (!bus.a_valid || !m_last);
    chk("a_ready", bus.a_ready, g_a);
    chk("b_ready", bus.b_ready, g_b);
    chk("one_ready", bus.a_ready & bus.b_ready, 1'b0);
    chk("avm_write", bus.avm_write, m_busy);
    chk("busy", bus.busy, m_busy);
    chk("drop_count", bus.drop_count, (m_drops > 65535) ? 65535 : m_drops);
    if (m_busy) begin
      chk("avm_address", bus.avm_address, m_addr);
      chk("avm_writedata", bus.avm_writedata, m_data);
    end
    if (log_en && bus.a_ready) grant_log.push_back(0);
    if (log_en && bus.b_ready) grant_log.push_back(1);
    if (m_busy) begin
      if (!bus.avm_waitrequest) m_busy = 0;
    end else if (g_a || g_b) begin
      m_last = g_b;
      sx = g_a ? int'(bus.a_x) : int'(bus.b_x);
      sy = g_a ? int'(bus.a_y) : int'(bus.b_y);
      sc = g_a ? bus.a_color : bus.b_color;
      if (sx < 640 && sy < 480) begin
        m_busy = 1; m_addr = pix_addr(sx, sy); m_data = sc;
      end else begin
        m_drops++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    bus.a_valid = 0; bus.a_x = '0; bus.a_y = '0; bus.a_color = '0;
    bus.b_valid = 0; bus.b_x = '0; bus.b_y = '0; bus.b_color = '0;
    bus.avm_waitrequest = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
  endtask

  initial begin
    int ia, ib, n;
    bit a_hold, b_hold;
    int dx[3], dy[3];

    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_avm_write", bus.avm_write, 1'b0);
    chk("rst_avm_address", bus.avm_address, 32'h0);
    chk("rst_avm_writedata", bus.avm_writedata, 16'h0);
    chk("rst_drop_count", bus.drop_count, 16'h0);
    chk("rst_busy", bus.busy, 1'b0);
    rst = 0;

    // Single write, no stall.
    bus.a_valid = 1; bus.a_x = 10'd3; bus.a_y = 10'd2; bus.a_color = 16'hF800;
    step();
    bus.a_valid = 0;
    chk("single_addr", bus.avm_address, 32'h0A06);
    chk("single_write", bus.avm_write, 1'b1);
    step();
    step();

    // Stalled write; B waits and is taken right after completion.
    bus.a_valid = 1;
    step();
    bus.a_valid = 0;
    bus.b_valid = 1; bus.b_x = 10'd5; bus.b_y = 10'd5; bus.b_color = 16'h1234;
    bus.avm_waitrequest = 1;
    repeat (3) step();
    bus.avm_waitrequest = 0;
    step();
    chk("stall_b_ready", bus.b_ready, 1'b1);
    step();
    bus.b_valid = 0;
    step();
    step();

    // Contention from reset: strict alternation, one write per 2 cycles.
    do_reset();
    ia = 0; ib = 0;
    grant_log.delete();
    log_en = 1;
    bus.a_valid = 1; bus.b_valid = 1;
    for (int c = 0; c < 16; c++) begin
      bus.a_x = 10'(ia * 10); bus.a_y = 10'(ia);       bus.a_color = 16'(16'hA000 + ia);
      bus.b_x = 10'(100 + ib); bus.b_y = 10'(200 + ib); bus.b_color = 16'(16'hB000 + ib);
      step();
      if (g_a) ia++;
      if (g_b) ib++;
    end
    log_en = 0;
    chk("contention_grants", grant_log.size(), 8);
    foreach (grant_log[i]) chk("contention_order", grant_log[i], i % 2);
    idle_inputs();
    step();

    // Out-of-range drops then a corner pixel.
    do_reset();
    dx = '{640, 0, 639};
    dy = '{0, 480, 479};
    ib = 0; n = 0;
    while (ib < 3 && n < 12) begin
      bus.b_valid = 1; bus.b_x = 10'(dx[ib]); bus.b_y = 10'(dy[ib]); bus.b_color = 16'h0F0F;
      step();
      n++;
      if (g_b) ib++;
      if (ib == 2 && g_b) chk("drop_two", bus.drop_count, 16'd2);
    end
    chk("drop_seq_done", ib, 3);
    bus.b_valid = 0;
    chk("corner_addr", bus.avm_address, 32'h0009_5FFE);
    chk("corner_write", bus.avm_write, 1'b1);
    step();
    step();

    // Saturation of the drop counter.
    bus.a_valid = 1; bus.a_x = 10'd640; bus.a_y = 10'd0;
    for (int c = 0; c < 65537; c++) step();
    chk("drop_saturated", bus.drop_count, 16'hFFFF);
    bus.a_valid = 0;
    step();

    // Reset in the middle of a stalled write.
    bus.a_valid = 1; bus.a_x = 10'd1; bus.a_y = 10'd1; bus.a_color = 16'h5555;
    bus.avm_waitrequest = 1;
    step();
    bus.a_valid = 0;
    #2;
    chk("pre_rst_write", bus.avm_write, 1'b1);
    rst = 1;
    #1;
    chk("rst_async_write", bus.avm_write, 1'b0);
    chk("rst_async_busy", bus.busy, 1'b0);
    chk("rst_async_drops", bus.drop_count, 16'h0);
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    bus.avm_waitrequest = 0;
    bus.a_valid = 1; bus.b_valid = 1;
    bus.b_x = 10'd7; bus.b_y = 10'd7; bus.b_color = 16'h7777;
    #2;
    chk("tie_after_reset", bus.a_ready, 1'b1);
    step();
    idle_inputs();
    step();
    step();

    // Randomized traffic with source hold rules and random stalls.
    a_hold = 0; b_hold = 0;
    for (int c = 0; c < 600; c++) begin
      if (!a_hold) begin
        bus.a_valid = 1'($urandom_range(0, 1));
        bus.a_x = 10'($urandom_range(0, 700));
        bus.a_y = 10'($urandom_range(0, 520));
        bus.a_color = 16'($urandom);
      end
      if (!b_hold) begin
        bus.b_valid = 1'($urandom_range(0, 1));
        bus.b_x = 10'($urandom_range(0, 700));
        bus.b_y = 10'($urandom_range(0, 520));
        bus.b_color = 16'($urandom);
      end
      bus.avm_waitrequest = ($urandom_range(0, 3) == 0);
      step();
      a_hold = bus.a_valid && !g_a;
      b_hold = bus.b_valid && !g_b;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/draw_write_arbiter.md
Name: draw_write_arbiter

Overview:
- Shares the SDRAM framebuffer write path between two pixel-draw sources: A = local touch-panel strokes, B = strokes received over the wifi UART.
- Each source presents an (x, y, colour) pixel request with a valid/ready handshake.
- The block arbitrates between them round-robin, range-checks the coordinate, and converts it to a byte address.
- It issues one Avalon-MM write per accepted pixel toward the SDRAM controller in the cpu system. Out-of-range pixels are dropped and counted.

Parameters:
- H_RES, 640, framebuffer width in pixels
- V_RES, 480, framebuffer height in pixels
- X_W, 10, x coordinate width
- Y_W, 10, y coordinate width
- COLOR_W, 16, pixel width in bits; must be 8, 16 or 32
- ADDR_W, 32, Avalon byte-address width
- BASE_ADDR, 32'h0000_0000, framebuffer byte base address

Ports:
- clk_clk  in  1  system clock; single clock domain
- reset_reset  in  1  asynchronous, active-high reset
- a_valid  in  1  source A request valid
- a_ready  out  1  source A request accepted this cycle
- a_x  in  X_W  source A pixel column
- a_y  in  Y_W  source A pixel row
- a_color  in  COLOR_W  source A pixel value
- b_valid, b_ready, b_x, b_y, b_color  same as A, for source B
- avm_address  out  ADDR_W  write byte address
- avm_write  out  1  write strobe
- avm_writedata  out  COLOR_W  write data
- avm_waitrequest  in  1  slave stall
- drop_count  out  16  saturating count of out-of-range requests
- busy  out  1  high while a write is outstanding (state ISSUE)

Behaviour:
- Reset values: avm_write=0, avm_address=0, avm_writedata=0, drop_count=0, state=IDLE, last_grant=B (so A wins the first tie).
- a_ready and b_ready are combinational from state, last_grant and the valids. They must never depend on avm_waitrequest.
- A transfer occurs on a rising edge where valid&ready=1.
- States:
  - IDLE: at most one ready is high, and only while state=IDLE.
    - If only one valid is high, that source is granted.
    - If both are high, the source not equal to last_grant is granted.
    - If none is high, both readies are 0.
  - On a transfer:
    - last_grant is set to the granted source.
    - In range (x<H_RES and y<V_RES): register address and data, then go to ISSUE.
    - Out of range: drop the pixel, increment drop_count (saturating at 16'hFFFF), stay in IDLE, issue no bus cycle.
  - ISSUE: avm_write=1; avm_address and avm_writedata are held stable.
    - When avm_waitrequest=0 on an edge, the write completes; set avm_write=0 and return to IDLE.
    - No request is accepted while in ISSUE.
- Address: avm_address = BASE_ADDR + (y*H_RES + x) * (COLOR_W/8).
  - Compute in ADDR_W bits, unsigned.
  - The product is formed only after the range check passes, so there is no wrap.
- Latency and throughput:
  - avm_write rises on the cycle after acceptance.
  - Minimum 2 cycles per pixel.
  - A dropped pixel takes 1 cycle, and the next request can be accepted on the following cycle.
- Fairness: with both sources continuously valid, grants alternate strictly A, B, A, B. Drops count as grants for alternation.
- Reset mid-ISSUE: avm_write deasserts immediately (asynchronously); the in-flight pixel is discarded; state returns to IDLE.
- Sources must hold x, y and colour stable while valid is high and ready is low. The arbiter samples them only on the transfer edge.

Test Plan:
- Single write, no stall:
  - Stimulus: A sends (3,2,16'hF800), avm_waitrequest=0.
  - Required: a_ready=1 in the same cycle; next cycle avm_write=1, avm_address=32'h0A06, avm_writedata=16'hF800; following cycle avm_write=0 and busy=0.
- Stalled write:
  - Stimulus: same request, avm_waitrequest held high for 3 cycles.
  - Required: avm_write stays high 4 cycles with address/data unchanged; a_ready and b_ready stay 0 throughout; b_valid held high is accepted the cycle after completion.
- Contention:
  - Stimulus: a_valid=b_valid=1 continuously after reset, with distinct pixels.
  - Required: grant order A, B, A, B; exactly one ready per acceptance; one write every 2 cycles.
- Out-of-range drops:
  - Stimulus: B sends (640,0), then (0,480), then (639,479).
  - Required: first two produce no avm_write and drop_count=2; third writes address 32'h9_5FFE.
- Saturation:
  - Stimulus: force 65537 out-of-range requests.
  - Required: drop_count=16'hFFFF and no wrap.
- Reset during ISSUE:
  - Stimulus: assert reset_reset mid-write while avm_waitrequest=1.
  - Required: avm_write=0 immediately; after release, state=IDLE, drop_count=0, and A wins the first tie.
